// File: rtl/avg_frame_sequencer.sv
// Frame-aligned averaging sequencer: locks onto FFT frame boundaries, gates
// accumulation of 2^L frames per average, then hands the result downstream.
module avg_frame_sequencer #(
  parameter int FRAME_BEATS = 1024,
  parameter int N_AVGS      = 7,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          arest,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          abort,
  input  logic [$clog2(N_AVGS+1)-1:0]   log2_avgs,
  input  logic                          fft_valid,
  input  logic                          fft_last,
  input  logic                          out_ready,
  output logic                          acc_en,
  output logic                          acc_clear,
  output logic                          dump_valid,
  output logic                          busy,
  output logic [CNT_W-1:0]              frames_done,
  output logic                          err_frame,
  output logic                          err_overrun
);

  localparam int LW = $clog2(N_AVGS + 1);
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int FW = N_AVGS + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
  localparam logic [LW-1:0] MAX_LOG2  = LW'(N_AVGS);

  typedef enum logic [1:0] {IDLE, SYNC, ACCUM, DUMP} state_t;

  state_t        state;
  logic [LW-1:0] avg_log2;
  logic [BW-1:0] beat_cnt;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_last;
  logic          stop_pend;
  logic          ovr_dump;
  logic          handshake;
  logic          sync_hit;

  assign frame_last = (FW'(1) << avg_log2) - FW'(1);
  assign handshake  = (state == DUMP) && dump_valid && out_ready && !abort;
  assign sync_hit   = (state == SYNC) && fft_valid && fft_last && !abort;
  assign acc_en     = (state == ACCUM) && fft_valid;
  assign acc_clear  = sync_hit || handshake;
  assign busy       = (state != IDLE);

  // ovr_dump remembers an overrun within the current dump only, since
  // err_overrun itself is sticky across averages.
  always_ff @(posedge clk or posedge arest) begin
    if (arest) begin
      state       <= IDLE;
      avg_log2    <= '0;
      beat_cnt    <= '0;
      frame_cnt   <= '0;
      stop_pend   <= 1'b0;
      ovr_dump    <= 1'b0;
      dump_valid  <= 1'b0;
      frames_done <= '0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      frame_cnt  <= '0;
      stop_pend  <= 1'b0;
      ovr_dump   <= 1'b0;
      dump_valid <= 1'b0;
    end else begin
      if (stop && state != IDLE) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            avg_log2    <= (log2_avgs > MAX_LOG2) ? MAX_LOG2 : log2_avgs;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            state       <= SYNC;
          end
        end
        SYNC: begin
          if (fft_valid && fft_last) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          // A frame is malformed if last and the final beat index disagree.
          if (fft_valid) begin
            if (fft_last != (beat_cnt == LAST_BEAT)) begin
              err_frame <= 1'b1;
              beat_cnt  <= '0;
              frame_cnt <= '0;
              state     <= SYNC;
            end else if (fft_last) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + FW'(1);
              if (frame_cnt == frame_last) begin
                dump_valid <= 1'b1;
                state      <= DUMP;
              end
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        DUMP: begin
          if (fft_valid) begin
            err_overrun <= 1'b1;
            ovr_dump    <= 1'b1;
          end
          if (dump_valid && out_ready) begin
            dump_valid  <= 1'b0;
            frames_done <= frames_done + CNT_W'(1);
            frame_cnt   <= '0;
            ovr_dump    <= 1'b0;
            if (stop_pend || stop) begin
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else if (ovr_dump || fft_valid) begin
              state <= SYNC;
            end else begin
              state <= ACCUM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_frame_sequencer.sv
// Directed bench for avg_frame_sequencer: 8-beat frames, hand-computed dump
// counts, error flags, stop/abort/reset behaviour and log2 clamping.
module tb_avg_frame_sequencer;

  logic       clk = 1'b0;
  logic       arest = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] log2_avgs = 3'd0;
  logic       fft_valid = 1'b0;
  logic       fft_last = 1'b0;
  logic       out_ready = 1'b0;
  logic        acc_en, acc_clear, dump_valid, busy, err_frame, err_overrun;
  logic [31:0] frames_done;
  logic        acc_en2, acc_clear2, dump_valid2, busy2, err_frame2, err_overrun2;
  logic [7:0]  frames_done2;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int clr_cnt = 0;
  int acc_cnt = 0;

  avg_frame_sequencer #(.FRAME_BEATS(8), .N_AVGS(7), .CNT_W(32)) dut (
    .clk(clk), .arest(arest), .start(start), .stop(stop), .abort(abort),
    .log2_avgs(log2_avgs), .fft_valid(fft_valid), .fft_last(fft_last),
    .out_ready(out_ready), .acc_en(acc_en), .acc_clear(acc_clear),
    .dump_valid(dump_valid), .busy(busy), .frames_done(frames_done),
    .err_frame(err_frame), .err_overrun(err_overrun)
  );

  // Second instance with a smaller N_AVGS so a request of 7 gets clamped to 5.
  avg_frame_sequencer #(.FRAME_BEATS(8), .N_AVGS(5), .CNT_W(8)) dut_clamp (
    .clk(clk), .arest(arest), .start(start), .stop(stop), .abort(abort),
    .log2_avgs(log2_avgs), .fft_valid(fft_valid), .fft_last(fft_last),
    .out_ready(out_ready), .acc_en(acc_en2), .acc_clear(acc_clear2),
    .dump_valid(dump_valid2), .busy(busy2), .frames_done(frames_done2),
    .err_frame(err_frame2), .err_overrun(err_overrun2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dump_valid && out_ready) hs_cnt++;
    if (acc_clear) clr_cnt++;
    if (acc_en) acc_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic l);
    fft_valid = v;
    fft_last  = l;
    tick();
    fft_valid = 1'b0;
    fft_last  = 1'b0;
  endtask

  // Two idle cycles follow each frame so a dump handshake never sees a beat.
  task automatic sendFrame(input int n_beats, input int last_at);
    for (int i = 0; i < n_beats; i++) applyStimulus(1'b1, i == last_at);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sendFrames(input int n);
    for (int i = 0; i < n; i++) sendFrame(8, 7);
  endtask

  task automatic pulseStart(input logic [2:0] l2);
    log2_avgs = l2;
    start = 1'b1;
    applyStimulus(1'b0, 1'b0);
    start = 1'b0;
  endtask

  // Drives one non-last beat and checks the combinational accumulate enable.
  task automatic probeAccEn(input string tag, input logic exp);
    fft_valid = 1'b1;
    fft_last  = 1'b0;
    #1;
    checkOutput(tag, acc_en, exp);
    tick();
    fft_valid = 1'b0;
  endtask

  initial begin
    #1 arest = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dump_valid", dump_valid, 0);
    checkOutput("rst_frames_done", frames_done, 0);
    checkOutput("rst_errs", {err_frame, err_overrun}, 0);
    checkOutput("rst_acc", {acc_en, acc_clear}, 0);
    tick();
    tick();
    arest = 1'b0;
    tick();

    // Partial frame skipped, 4 frames averaged, then two more frames.
    out_ready = 1'b1;
    pulseStart(3'd2);
    checkOutput("start_busy", busy, 1);
    sendFrame(3, 2);
    sendFrames(4);
    checkOutput("avg4_handshakes", hs_cnt, 1);
    checkOutput("avg4_frames_done", frames_done, 1);
    checkOutput("avg4_clears", clr_cnt, 2);
    checkOutput("avg4_acc_beats", acc_cnt, 32);
    sendFrames(2);
    checkOutput("avg6_frames_done", frames_done, 1);
    checkOutput("avg6_acc_beats", acc_cnt, 48);

    // Backpressure hold with an overrun beat during the dump.
    out_ready = 1'b0;
    sendFrames(2);
    for (int i = 0; i < 5; i++) applyStimulus(i == 2, 1'b0);
    checkOutput("hold_dump_valid", dump_valid, 1);
    checkOutput("hold_err_overrun", err_overrun, 1);
    checkOutput("hold_frames_done", frames_done, 1);
    checkOutput("hold_acc_beats", acc_cnt, 64);
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold_release_frames_done", frames_done, 2);
    checkOutput("hold_release_dump_valid", dump_valid, 0);
    probeAccEn("overrun_goes_sync", 1'b0);

    // Short frame inside an average.
    sendFrame(8, 7);
    sendFrame(6, 5);
    checkOutput("short_err_frame", err_frame, 1);
    probeAccEn("short_goes_sync", 1'b0);
    sendFrames(4);
    checkOutput("short_no_dump", hs_cnt, 2);
    sendFrames(1);
    checkOutput("short_next_dump", frames_done, 3);

    // Eight beats with no last marker.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
    probeAccEn("nolast_goes_sync", 1'b0);

    // Stop mid-average: this average completes, then idle.
    sendFrames(2);
    stop = 1'b1;
    applyStimulus(1'b0, 1'b0);
    stop = 1'b0;
    checkOutput("stop_still_busy", busy, 1);
    sendFrames(3);
    checkOutput("stop_frames_done", frames_done, 4);
    checkOutput("stop_idle", busy, 0);
    probeAccEn("stop_no_acc", 1'b0);

    // L=0 with dump held, then abort together with start.
    out_ready = 1'b0;
    pulseStart(3'd0);
    checkOutput("restart_errs_cleared", {err_frame, err_overrun}, 0);
    sendFrames(2);
    checkOutput("l0_dump_valid", dump_valid, 1);
    abort = 1'b1;
    start = 1'b1;
    applyStimulus(1'b0, 1'b0);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_dump_valid", dump_valid, 0);
    checkOutput("abort_frames_done", frames_done, 4);

    // L=0 dumps on every frame.
    out_ready = 1'b1;
    pulseStart(3'd0);
    sendFrames(4);
    checkOutput("l0_frames_done", frames_done, 7);
    abort = 1'b1;
    applyStimulus(1'b0, 1'b0);
    abort = 1'b0;

    // Asynchronous reset in the middle of a frame.
    pulseStart(3'd2);
    sendFrames(3);
    fft_valid = 1'b1;
    #2 arest = 1'b1;
    #1;
    checkOutput("arest_busy", busy, 0);
    checkOutput("arest_acc_en", acc_en, 0);
    checkOutput("arest_frames_done", frames_done, 0);
    fft_valid = 1'b0;
    tick();
    tick();
    arest = 1'b0;
    sendFrames(4);
    checkOutput("arest_no_dump", hs_cnt, 7);
    checkOutput("arest_stays_idle", busy, 0);

    // log2 request of 7: full 128 frames here, clamped to 32 in dut_clamp.
    pulseStart(3'd7);
    sendFrames(128);
    checkOutput("l7_frames_done_127", frames_done, 0);
    checkOutput("clamp_frames_done_127", frames_done2, 3);
    sendFrames(1);
    checkOutput("l7_frames_done_128", frames_done, 1);
    checkOutput("clamp_frames_done_128", frames_done2, 4);
    checkOutput("l7_no_overrun", err_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
